// File: rtl/serv_ibus_bytefetch.sv
// serv_ibus_bytefetch
// Answers 32-bit instruction fetches from a byte-wide synchronous memory.
// A miss reads four bytes in a row and builds the word in little-endian order.
// A one-word buffer (tag + valid) lets a repeat fetch of the same word
// be acknowledged one cycle after the request.
// Fetch address bits above AW-1 are ignored, so the memory repeats (aliases)
// across the address space.

module serv_ibus_bytefetch #(
   parameter int AW       = 12,
   parameter bit WITH_BUF = 1'b1
) (
   input  logic          clk,
   input  logic          i_rst,
   input  logic [31:0]   i_ibus_adr,
   input  logic          i_ibus_cyc,
   output logic [31:0]   o_ibus_rdt,
   output logic          o_ibus_ack,
   input  logic          i_inv,
   output logic [AW-1:0] o_mem_adr,
   output logic          o_mem_rd,
   input  logic [7:0]    i_mem_rdt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_LAST  = 2'd2;
   localparam logic [1:0] S_ACK   = 2'd3;

   logic [1:0]    r_state;
   logic [AW-3:0] r_word;
   logic [1:0]    r_cnt;
   logic [AW-3:0] r_tag;
   logic          r_valid;
   logic          r_invSeen;
   logic [31:0]   r_rdt;
   logic          r_ack;

   logic          w_hit;
   logic          w_miss;
   logic          w_unused;

   // The byte-lane bits and the aliased upper address bits never affect the word fetched
   assign w_unused = ^{i_ibus_adr[31:AW], i_ibus_adr[1:0]};

   // A hit needs a valid buffered word with a matching tag.
   // An invalidate in the same cycle turns the hit into a miss.
   assign w_hit  = WITH_BUF && r_valid && !i_inv && (i_ibus_adr[AW-1:2] == r_tag);
   assign w_miss = (r_state == S_IDLE) && i_ibus_cyc && !w_hit;

   // Memory reads happen only in FETCH.
   // The byte address is the latched word address plus the byte counter.
   assign o_mem_rd   = (r_state == S_FETCH);
   assign o_mem_adr  = {r_word, r_cnt};
   assign o_ibus_rdt = r_rdt;
   assign o_ibus_ack = r_ack;

   // Main sequencer.
   // The ack register is set only on entry to ACK, so it stays high for exactly one cycle.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_ack   <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_ibus_cyc) begin
                  if (w_hit) begin
                     r_state <= S_ACK;
                     r_ack   <= 1'b1;
                  end else begin
                     r_state <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (r_cnt == 2'd3) begin
                  r_state <= S_LAST;
               end
            end
            S_LAST: begin
               if (i_ibus_cyc) begin
                  r_state <= S_ACK;
                  r_ack   <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_ACK: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Latch the word address when a miss starts.
   // Step the byte counter once per read; it wraps back to zero as FETCH ends.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_word <= '0;
         r_cnt  <= 2'd0;
      end else if (w_miss) begin
         r_word <= i_ibus_adr[AW-1:2];
         r_cnt  <= 2'd0;
      end else if (r_state == S_FETCH) begin
         r_cnt <= r_cnt + 2'd1;
      end
   end

   // Memory data arrives one cycle after each read.
   // Lane cnt-1 is filled during FETCH; the last byte is filled in LAST.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_rdt <= '0;
      end else if (r_state == S_FETCH) begin
         case (r_cnt)
            2'd1:    r_rdt[7:0]   <= i_mem_rdt;
            2'd2:    r_rdt[15:8]  <= i_mem_rdt;
            2'd3:    r_rdt[23:16] <= i_mem_rdt;
            default: r_rdt        <= r_rdt;
         endcase
      end else if (r_state == S_LAST) begin
         r_rdt[31:24] <= i_mem_rdt;
      end
   end

   // Track whether an invalidate arrived while a fetch was in progress.
   // If one did, the completed word must not be marked valid.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_invSeen <= 1'b0;
      end else if (w_miss) begin
         r_invSeen <= 1'b0;
      end else if (((r_state == S_FETCH) || (r_state == S_LAST)) && i_inv) begin
         r_invSeen <= 1'b1;
      end
   end

   // Update the buffer tag and valid flag.
   // An invalidate always wins.
   // Otherwise a fetch that completes cleanly fills the buffer, even without an ack.
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
      end else if (i_inv) begin
         r_valid <= 1'b0;
      end else if (WITH_BUF && (r_state == S_LAST) && !r_invSeen) begin
         r_valid <= 1'b1;
         r_tag   <= r_word;
      end
   end

endmodule
